// File: rtl/mac_tx.sv
// Ethernet MAC transmit path: user byte stream in, PCS control/data words out.
// Adds preamble/SFD, zero padding, CRC-32 FCS and the inter-packet gap.
module mac_tx #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter bit IS_10G      = 1'b1,
  parameter int IPG_CYC     = 6,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  output logic              ready_o,
  input  logic              cancel_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ctrl_v_o,
  output logic              idle_o,
  output logic              start_o,
  output logic              term_o,
  output logic [KEEP_W-1:0] term_keep_o,
  output logic              cancel_o
);

  if (DATA_W != 16) begin : g_bad_width
    $error("mac_tx: only DATA_W = 16 is supported");
  end
  if (KEEP_W != DATA_W / 8 || IS_10G != 1'b1 || (MIN_PAYLOAD % 2) != 0) begin : g_bad_cfg
    $error("mac_tx: unsupported KEEP_W / IS_10G / MIN_PAYLOAD combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_TERM, S_IPG} state_e;

  // state_q names the phase that produces the word loaded at the next edge.
  state_e      state_q;
  logic [1:0]  pre_q;
  logic [15:0] cnt_q;
  logic [31:0] crc_q;
  logic        odd_q;
  logic        fcs_ph_q;
  logic [7:0]  ipg_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat(input logic [16:0] s);
    return (s >= 17'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : s[15:0];
  endfunction

  logic        odd_beat_d;
  logic [16:0] sum_d;
  logic [16:0] sum_pad_d;
  logic [16:0] pad_sum_d;
  logic [31:0] crc_lo_d;
  logic [31:0] crc_beat_d;
  logic [31:0] crc_fill_d;
  logic [31:0] crc_zero_d;
  logic [31:0] fcs_d;
  logic [31:0] fcs_lo_d;

  assign odd_beat_d = last_i && (keep_i != '1);
  assign sum_d      = {1'b0, cnt_q} + (odd_beat_d ? 17'd1 : 17'd2);
  assign sum_pad_d  = sum_d + 17'd1;
  assign pad_sum_d  = {1'b0, cnt_q} + 17'd2;
  assign crc_lo_d   = crc_byte(crc_q, data_i[7:0]);
  assign crc_beat_d = crc_byte(crc_lo_d, data_i[15:8]);
  assign crc_fill_d = crc_byte(crc_lo_d, 8'h00);
  assign crc_zero_d = crc_byte(crc_byte(crc_q, 8'h00), 8'h00);
  assign fcs_d      = ~crc_q;
  assign fcs_lo_d   = ~crc_lo_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= '1;
      odd_q       <= 1'b0;
      fcs_ph_q    <= 1'b0;
      ipg_q       <= '0;
      ready_o     <= 1'b0;
      valid_o     <= 1'b0;
      data_o      <= '0;
      ctrl_v_o    <= 1'b0;
      idle_o      <= 1'b0;
      start_o     <= 1'b0;
      term_o      <= 1'b0;
      term_keep_o <= '0;
      cancel_o    <= 1'b0;
    end else begin
      // Default word is an idle control word; each phase overrides what differs.
      valid_o     <= 1'b1;
      data_o      <= '0;
      ctrl_v_o    <= 1'b1;
      idle_o      <= 1'b1;
      start_o     <= 1'b0;
      term_o      <= 1'b0;
      term_keep_o <= '0;
      cancel_o    <= 1'b0;
      ready_o     <= 1'b0;
      if ((state_q == S_PRE || state_q == S_PAD || state_q == S_FCS) && cancel_i
          || state_q == S_DATA && (cancel_i || !valid_i)) begin
        idle_o   <= 1'b0;
        cancel_o <= 1'b1;
        ipg_q    <= '0;
        state_q  <= S_IPG;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (valid_i) begin
              idle_o  <= 1'b0;
              start_o <= 1'b1;
              data_o  <= 16'h5555;
              pre_q   <= 2'd1;
              cnt_q   <= '0;
              crc_q   <= '1;
              odd_q   <= 1'b0;
              state_q <= S_PRE;
            end
          end
          S_PRE: begin
            idle_o   <= 1'b0;
            ctrl_v_o <= 1'b0;
            data_o   <= (pre_q == 2'd3) ? 16'hD555 : 16'h5555;
            pre_q    <= pre_q + 2'd1;
            if (pre_q == 2'd3) begin
              ready_o <= 1'b1;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            idle_o   <= 1'b0;
            ctrl_v_o <= 1'b0;
            fcs_ph_q <= 1'b0;
            cnt_q    <= sat(sum_d);
            if (!last_i) begin
              data_o  <= data_i;
              crc_q   <= crc_beat_d;
              ready_o <= 1'b1;
            end else if (!odd_beat_d) begin
              data_o  <= data_i;
              crc_q   <= crc_beat_d;
              state_q <= (sum_d < 17'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
            end else if (sum_d < 17'(MIN_PAYLOAD)) begin
              // Short odd frame: zero-fill the upper byte so padding stays word aligned.
              data_o  <= {8'h00, data_i[7:0]};
              crc_q   <= crc_fill_d;
              cnt_q   <= sat(sum_pad_d);
              state_q <= (sum_pad_d < 17'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
            end else begin
              data_o  <= {fcs_lo_d[7:0], data_i[7:0]};
              crc_q   <= crc_lo_d;
              odd_q   <= 1'b1;
              state_q <= S_FCS;
            end
          end
          S_PAD: begin
            idle_o   <= 1'b0;
            ctrl_v_o <= 1'b0;
            crc_q    <= crc_zero_d;
            cnt_q    <= sat(pad_sum_d);
            if (pad_sum_d >= 17'(MIN_PAYLOAD)) state_q <= S_FCS;
          end
          S_FCS: begin
            idle_o   <= 1'b0;
            ctrl_v_o <= 1'b0;
            if (odd_q) begin
              data_o  <= fcs_d[23:8];
              state_q <= S_TERM;
            end else if (!fcs_ph_q) begin
              data_o   <= fcs_d[15:0];
              fcs_ph_q <= 1'b1;
            end else begin
              data_o  <= fcs_d[31:16];
              state_q <= S_TERM;
            end
          end
          S_TERM: begin
            idle_o      <= 1'b0;
            term_o      <= 1'b1;
            data_o      <= odd_q ? {8'h00, fcs_d[31:24]} : 16'h0000;
            term_keep_o <= odd_q ? 2'b01 : 2'b00;
            ipg_q       <= '0;
            state_q     <= S_IPG;
          end
          S_IPG: begin
            ipg_q <= ipg_q + 8'd1;
            if (ipg_q == 8'(IPG_CYC - 1)) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
